multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multicycle RV32I-style datapath. Each instruction walks
//   FETCH -> DECODE -> EXEC [-> MEM] [-> WB]. Unsupported encodings park the
//   controller in TRAP until reset.
//
// Ports
//   sysCLK         clock, rising edge
//   pRST           asynchronous active-high reset
//   instr[31:0]    instruction word, valid while state is FETCH
//   BrEq, BrLt     rs1/rs2 comparator results
//   memReady       data-memory completion, sampled in MEM
//   PCWEn, PCSel   PC write enable / select (0 = PC+4, 1 = ALU)
//   IRWEn          instruction register write enable
//   ASel, BSel     ALU operand selects (ASel 1 = PC, BSel 1 = immediate)
//   BrUn           unsigned branch compare
//   MemReq, MemRW  data-memory request / direction (1 = write)
//   RegWEn         register file write enable
//   ImmSel[2:0]    immediate format (I, S, SB, U, UJ)
//   ALUSel[3:0]    ALU operation
//   WBSel[1:0]     write-back source (ALU, memory, PC+4)
//   state[2:0]     current FSM state
//   illegal        high while trapped
//   retired        count of PC updates, wraps
module multicycle_controller #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             sysCLK,
    input  logic             pRST,
    input  logic [31:0]      instr,
    input  logic             BrEq,
    input  logic             BrLt,
    input  logic             memReady,
    output logic             PCWEn,
    output logic             PCSel,
    output logic             IRWEn,
    output logic             ASel,
    output logic             BSel,
    output logic             BrUn,
    output logic             MemReq,
    output logic             MemRW,
    output logic             RegWEn,
    output logic [2:0]       ImmSel,
    output logic [3:0]       ALUSel,
    output logic [1:0]       WBSel,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_t;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_SB = 3'd2,
        IMM_U  = 3'd3,
        IMM_UJ = 3'd4
    } imm_t;

    state_t           state_q, state_d;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] retired_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       ir_unused;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign funct7    = ir_q[31:25];
    // Register and immediate fields belong to the datapath, not the controller.
    assign ir_unused = ^{ir_q[24:15], ir_q[11:7]};

    logic is_r, is_i, is_load, is_store, is_branch;
    logic is_lui, is_auipc, is_jal, is_jalr;
    logic known_op, decode_bad;

    always_comb begin
        is_r      = (opcode == 7'b0110011);
        is_i      = (opcode == 7'b0010011);
        is_load   = (opcode == 7'b0000011);
        is_store  = (opcode == 7'b0100011);
        is_branch = (opcode == 7'b1100011);
        is_lui    = (opcode == 7'b0110111);
        is_auipc  = (opcode == 7'b0010111);
        is_jal    = (opcode == 7'b1101111);
        is_jalr   = (opcode == 7'b1100111);
        known_op  = is_r | is_i | is_load | is_store | is_branch |
                    is_lui | is_auipc | is_jal | is_jalr;

        decode_bad = !known_op;
        if (is_r) begin
            if (funct7 != 7'b0000000 && funct7 != 7'b0100000)
                decode_bad = 1'b1;
            if (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101)
                decode_bad = 1'b1;
        end
        if (is_branch && (funct3 == 3'b010 || funct3 == 3'b011))
            decode_bad = 1'b1;
        if (is_i && (funct3 == 3'b001 || funct3 == 3'b101) &&
            funct7 != 7'b0000000 && funct7 != 7'b0100000)
            decode_bad = 1'b1;
    end

    logic taken;

    always_comb begin
        case (funct3)
            3'b000:  taken = BrEq;
            3'b001:  taken = !BrEq;
            3'b100:  taken = BrLt;
            3'b101:  taken = !BrLt;
            3'b110:  taken = BrLt;
            3'b111:  taken = !BrLt;
            default: taken = 1'b0;
        endcase
    end

    // ALU-side controls depend only on IR, held steady through EXEC/MEM/WB.
    logic alu_active;
    alu_t alu_c;
    imm_t imm_c;
    logic asel_c, bsel_c, brun_c;

    always_comb begin
        alu_c  = ALU_ADD;
        imm_c  = IMM_I;
        asel_c = 1'b0;
        bsel_c = 1'b0;
        brun_c = 1'b0;
        alu_active = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
        if (alu_active) begin
            if (is_r || is_i) begin
                bsel_c = is_i;
                case (funct3)
                    3'b000:  alu_c = (is_r && ir_q[30]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_c = ALU_SLL;
                    3'b010:  alu_c = ALU_SLT;
                    3'b011:  alu_c = ALU_SLTU;
                    3'b100:  alu_c = ALU_XOR;
                    3'b101:  alu_c = ir_q[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_c = ALU_OR;
                    default: alu_c = ALU_AND;
                endcase
            end else if (is_load || is_jalr) begin
                bsel_c = 1'b1;
            end else if (is_store) begin
                bsel_c = 1'b1;
                imm_c  = IMM_S;
            end else if (is_branch) begin
                asel_c = 1'b1;
                bsel_c = 1'b1;
                imm_c  = IMM_SB;
                brun_c = funct3[1];
            end else if (is_jal) begin
                asel_c = 1'b1;
                bsel_c = 1'b1;
                imm_c  = IMM_UJ;
            end else if (is_auipc) begin
                asel_c = 1'b1;
                bsel_c = 1'b1;
                imm_c  = IMM_U;
            end else if (is_lui) begin
                bsel_c = 1'b1;
                imm_c  = IMM_U;
                alu_c  = ALU_PASSB;
            end
        end
    end

    logic       pcwen_c, pcsel_c, irwen_c, memreq_c, memrw_c, regwen_c;
    logic [1:0] wbsel_c;

    always_comb begin
        state_d  = state_q;
        pcwen_c  = 1'b0;
        pcsel_c  = 1'b0;
        irwen_c  = 1'b0;
        memreq_c = 1'b0;
        memrw_c  = 1'b0;
        regwen_c = 1'b0;
        wbsel_c  = 2'b00;
        case (state_q)
            S_FETCH: begin
                irwen_c = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = decode_bad ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                if (is_branch) begin
                    pcwen_c = 1'b1;
                    pcsel_c = taken;
                    state_d = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                memreq_c = 1'b1;
                memrw_c  = is_store;
                if (memReady) begin
                    if (is_store) begin
                        pcwen_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                regwen_c = 1'b1;
                pcwen_c  = 1'b1;
                pcsel_c  = is_jal || is_jalr;
                if (is_load)
                    wbsel_c = 2'b01;
                else if (is_jal || is_jalr)
                    wbsel_c = 2'b10;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge sysCLK or posedge pRST) begin
        if (pRST) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (irwen_c)
                ir_q <= instr;
            if (pcwen_c)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Reset gates the enables directly so they drop without waiting for a clock.
    assign PCWEn   = pcwen_c  & ~pRST;
    assign IRWEn   = irwen_c  & ~pRST;
    assign MemReq  = memreq_c & ~pRST;
    assign MemRW   = memrw_c  & ~pRST;
    assign RegWEn  = regwen_c & ~pRST;
    assign PCSel   = pcsel_c;
    assign WBSel   = wbsel_c;
    assign ASel    = asel_c;
    assign BSel    = bsel_c;
    assign BrUn    = brun_c;
    assign ImmSel  = imm_c;
    assign ALUSel  = alu_c;
    assign state   = state_q;
    assign illegal = (state_q == S_TRAP);
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Randomized bench for multicycle_controller. A per-instruction reference
//   model derives the expected state walk and control values from the
//   instruction class, then each cycle is compared against the DUT.
module tb_multicycle_controller;

    localparam int unsigned CNT_W = 4;

    logic             sysCLK = 1'b0;
    logic             pRST;
    logic [31:0]      instr;
    logic             BrEq, BrLt, memReady;
    logic             PCWEn, PCSel, IRWEn, ASel, BSel, BrUn;
    logic             MemReq, MemRW, RegWEn;
    logic [2:0]       ImmSel;
    logic [3:0]       ALUSel;
    logic [1:0]       WBSel;
    logic [2:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .sysCLK   (sysCLK),
        .pRST     (pRST),
        .instr    (instr),
        .BrEq     (BrEq),
        .BrLt     (BrLt),
        .memReady (memReady),
        .PCWEn    (PCWEn),
        .PCSel    (PCSel),
        .IRWEn    (IRWEn),
        .ASel     (ASel),
        .BSel     (BSel),
        .BrUn     (BrUn),
        .MemReq   (MemReq),
        .MemRW    (MemRW),
        .RegWEn   (RegWEn),
        .ImmSel   (ImmSel),
        .ALUSel   (ALUSel),
        .WBSel    (WBSel),
        .state    (state),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 sysCLK = ~sysCLK;

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned model_retired = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Instruction classes: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH,
    // 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, -1 unknown.
    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'h33:   return 0;
            7'h13:   return 1;
            7'h03:   return 2;
            7'h23:   return 3;
            7'h63:   return 4;
            7'h37:   return 5;
            7'h17:   return 6;
            7'h6F:   return 7;
            7'h67:   return 8;
            default: return -1;
        endcase
    endfunction

    function automatic bit legal_of(input logic [31:0] ir);
        int c = cls_of(ir[6:0]);
        logic [2:0] f3 = ir[14:12];
        logic [6:0] f7 = ir[31:25];
        bit f7_ok = (f7 == 7'h00) || (f7 == 7'h20);
        if (c < 0) return 0;
        if (c == 0 && !f7_ok) return 0;
        if (c == 0 && f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5)) return 0;
        if (c == 4 && (f3 == 3'd2 || f3 == 3'd3)) return 0;
        if (c == 1 && (f3 == 3'd1 || f3 == 3'd5) && !f7_ok) return 0;
        return 1;
    endfunction

    function automatic logic [3:0] exp_alu(input logic [31:0] ir, input int c);
        logic [3:0] by_f3 [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        logic [2:0] f3 = ir[14:12];
        if (c == 5) return 4'd10;
        if (c == 0 || c == 1) begin
            if (c == 0 && f3 == 3'd0 && ir[30]) return 4'd1;
            if (f3 == 3'd5 && ir[30]) return 4'd7;
            return by_f3[f3];
        end
        return 4'd0;
    endfunction

    function automatic logic [2:0] exp_imm(input int c);
        case (c)
            3:       return 3'd1;
            4:       return 3'd2;
            5, 6:    return 3'd3;
            7:       return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'd0:    return eq;
            3'd1:    return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] exp_ret();
        return CNT_W'(model_retired % (32'd1 << CNT_W));
    endfunction

    // Asynchronous reset pulse; enters at posedge+>=1, leaves at posedge+1
    // with the DUT sitting in FETCH.
    task automatic do_reset();
        #1 pRST = 1'b1;
        #1;
        model_retired = 0;
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_ctl", {26'd0, IRWEn, PCWEn, RegWEn, MemReq, MemRW, illegal}, 32'd0);
        check_val("rst_retired", 32'(retired), 32'(exp_ret()));
        @(posedge sysCLK);
        #1 pRST = 1'b0;
    endtask

    // Runs one instruction from FETCH. rst_at >= 0 aborts with a reset pulse
    // in that cycle of the walk.
    task automatic run_instr(input logic [31:0] ir, input logic eq, input logic lt,
                             input int w, input int rst_at);
        int  c    = cls_of(ir[6:0]);
        bit  lg   = legal_of(ir);
        int  seq[$];
        int  mem_k = 0;
        int  st;
        logic [31:0] junk;
        logic exp_pcwen;

        seq.push_back(0);
        seq.push_back(1);
        if (!lg) begin
            seq.push_back(5); seq.push_back(5); seq.push_back(5);
        end else begin
            seq.push_back(2);
            if (c == 2 || c == 3)
                for (int k = 0; k <= w; k++) seq.push_back(3);
            if (c != 3 && c != 4)
                seq.push_back(4);
        end

        for (int i = 0; i < seq.size(); i++) begin
            st = seq[i];
            junk = $urandom;
            instr = (st == 0) ? ir : junk;
            BrEq  = eq;
            BrLt  = lt;
            if (st == 3) begin
                memReady = (mem_k == w);
                mem_k++;
            end else begin
                memReady = 1'($urandom_range(0, 1));
            end
            #1;
            exp_pcwen = lg && (i == seq.size() - 1);
            check_val("state", 32'(state), 32'(st));
            check_val("ctl", {26'd0, IRWEn, PCWEn, RegWEn, MemReq, MemRW, illegal},
                      {26'd0, 1'(st == 0), exp_pcwen, 1'(st == 4), 1'(st == 3),
                       1'(st == 3 && c == 3), 1'(st == 5)});
            check_val("retired", 32'(retired), 32'(exp_ret()));
            if (st >= 2 && st <= 4) begin
                check_val("asel_bsel", {30'd0, ASel, BSel},
                          {30'd0, 1'(c == 4 || c == 6 || c == 7), 1'(c != 0)});
                check_val("alusel", 32'(ALUSel), 32'(exp_alu(ir, c)));
                if (c != 0)
                    check_val("immsel", 32'(ImmSel), 32'(exp_imm(c)));
                if (c == 4)
                    check_val("brun", 32'(BrUn), 32'(ir[13]));
            end
            if (exp_pcwen)
                check_val("pcsel", 32'(PCSel),
                          32'((c == 4) ? br_taken(ir[14:12], eq, lt) : (c == 7 || c == 8)));
            if (st == 4)
                check_val("wbsel", 32'(WBSel),
                          32'((c == 2) ? 2'b01 : (c == 7 || c == 8) ? 2'b10 : 2'b00));
            if (i == rst_at) begin
                do_reset();
                return;
            end
            @(posedge sysCLK);
            #1;
        end
        if (lg) model_retired++;
        check_val("retired_end", 32'(retired), 32'(exp_ret()));
        if (!lg) begin
            check_val("trap_sticky", {29'd0, state}, 32'd5);
            do_reset();
        end
    endtask

    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    initial begin
        logic [31:0] r, ir;
        int k;
        pRST = 1'b0; instr = '0; BrEq = 1'b0; BrLt = 1'b0; memReady = 1'b0;
        #1 pRST = 1'b1;
        #1;
        check_val("por_state", 32'(state), 32'd0);
        check_val("por_ctl", {26'd0, IRWEn, PCWEn, RegWEn, MemReq, MemRW, illegal}, 32'd0);
        check_val("por_retired", 32'(retired), 32'd0);
        @(posedge sysCLK);
        @(posedge sysCLK);
        #1 pRST = 1'b0;

        run_instr(32'h002081B3, 1'b0, 1'b0, 0, -1);  // add
        run_instr(32'h00208463, 1'b1, 1'b0, 0, -1);  // beq taken
        run_instr(32'h00208463, 1'b0, 1'b0, 0, -1);  // beq not taken
        run_instr(32'h0000A183, 1'b0, 1'b0, 3, -1);  // lw, 3 wait cycles
        run_instr(32'h008000EF, 1'b0, 1'b0, 0, -1);  // jal
        run_instr(32'h0000007F, 1'b0, 1'b0, 0, -1);  // illegal opcode
        run_instr(32'h0010A023, 1'b0, 1'b0, 5, 4);   // sw, reset mid MEM wait
        run_instr(32'h0010A023, 1'b0, 1'b0, 1, -1);  // sw completes

        for (int n = 0; n < 150; n++) begin
            r = $urandom;
            k = int'($urandom_range(0, 9));
            ir = {r[31:7], (k == 9) ? r[6:0] : ops[k]};
            if (k == 0 && $urandom_range(0, 3) != 0) begin
                ir[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
                if (ir[31:25] == 7'h20 && $urandom_range(0, 3) != 0)
                    ir[14:12] = $urandom_range(0, 1) ? 3'd0 : 3'd5;
            end
            if (k == 1 && $urandom_range(0, 3) != 0)
                ir[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            if (k == 4 && $urandom_range(0, 3) != 0)
                ir[14:12] = br_f3[$urandom_range(0, 5)];
            run_instr(ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
